tri_stream_test: RTL and testbench

Parametrised, fully pipelined point-in-triangle tester; successor to the fixed-width orientation-sign pipeline. A triangle is loaded as three vertices, then query points stream in at one per cycle. Each point gets an inside/on-edge verdict after a fixed latency. Sits between the coordinate source and the raster/hit accumulator; a new triangle can be loaded while earlier queries drain.

---
 rtl/tri_stream_test_pkg.sv | 27 ++
 rtl/tri_stream_test_edge_fn.sv | 57 +++++
 rtl/tri_stream_test.sv | 156 +++++++++++++++
 tb/tb_tri_stream_test.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_stream_test_pkg.sv
// Shared widths and FSM encoding for the point-in-triangle pipeline.
// Widths are functions of the coordinate width W so every user derives them alike.
package tri_stream_test_pkg;

    typedef enum logic [1:0] {
        LOAD0 = 2'd0,
        LOAD1 = 2'd1,
        LOAD2 = 2'd2,
        RUN   = 2'd3
    } state_e;

    // signed coordinate difference
    function automatic int dw(input int w);
        return w + 1;
    endfunction

    // signed product of two differences
    function automatic int pw(input int w);
        return 2 * w + 2;
    endfunction

    // signed edge function value
    function automatic int ew(input int w);
        return 2 * w + 3;
    endfunction

endpackage

// File: rtl/tri_stream_test_edge_fn.sv
// One edge function E = (bx-ax)*(py-ay) - (by-ay)*(px-ax), pipelined.
// Ports: clk, rst, edge endpoints a/b and point p (unsigned W), e_o (signed EW).
// Stage 1 registers differences, stage 2 registers products; e_o is the
// combinational difference of the stage-2 products, registered by the caller.
module tri_edge_fn
    import tri_stream_test_pkg::*;
#(
    parameter int W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          ax_i,
    input  logic [W-1:0]          ay_i,
    input  logic [W-1:0]          bx_i,
    input  logic [W-1:0]          by_i,
    input  logic [W-1:0]          px_i,
    input  logic [W-1:0]          py_i,
    output logic signed [2*W+2:0] e_o
);

    localparam int DW = dw(W);
    localparam int PW = pw(W);
    localparam int EW = ew(W);

    logic signed [DW-1:0] dbx_d, dpy_d, dby_d, dpx_d;
    logic signed [DW-1:0] dbx_q, dpy_q, dby_q, dpx_q;
    logic signed [PW-1:0] m1_d, m2_d, m1_q, m2_q;

    assign dbx_d = $signed({1'b0, bx_i}) - $signed({1'b0, ax_i});
    assign dpy_d = $signed({1'b0, py_i}) - $signed({1'b0, ay_i});
    assign dby_d = $signed({1'b0, by_i}) - $signed({1'b0, ay_i});
    assign dpx_d = $signed({1'b0, px_i}) - $signed({1'b0, ax_i});

    assign m1_d = PW'(dbx_q) * PW'(dpy_q);
    assign m2_d = PW'(dby_q) * PW'(dpx_q);

    assign e_o = EW'(m1_q) - EW'(m2_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbx_q <= '0;
            dpy_q <= '0;
            dby_q <= '0;
            dpx_q <= '0;
            m1_q  <= '0;
            m2_q  <= '0;
        end else begin
            dbx_q <= dbx_d;
            dpy_q <= dpy_d;
            dby_q <= dby_d;
            dpx_q <= dpx_d;
            m1_q  <= m1_d;
            m2_q  <= m2_d;
        end
    end

endmodule

// File: rtl/tri_stream_test.sv
// Pipelined point-in-triangle tester: load three vertices, then stream points.
// Ports: clk, r (async reset), v_* vertex load, p_* query stream with p_ready,
// out_* verdict/tag three register stages after acceptance, tri_degen flag.
module tri_stream_test
    import tri_stream_test_pkg::*;
#(
    parameter int W         = 11,
    parameter int TAG_W     = 4,
    parameter int INCLUSIVE = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             v_valid,
    input  logic [W-1:0]     v_x,
    input  logic [W-1:0]     v_y,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [W-1:0]     p_x,
    input  logic [W-1:0]     p_y,
    input  logic [TAG_W-1:0] p_tag,
    output logic             out_valid,
    output logic             out_inside,
    output logic             out_edge,
    output logic [TAG_W-1:0] out_tag,
    output logic             tri_degen
);

    localparam int DW = dw(W);
    localparam int PW = pw(W);
    localparam int EW = ew(W);

    state_e           state_q;
    logic [W-1:0]     vx_q [3];
    logic [W-1:0]     vy_q [3];

    logic             v1_q, v2_q;
    logic [TAG_W-1:0] tag1_q, tag2_q;
    logic             deg1_q, deg2_q;

    logic signed [EW-1:0] e [3];

    logic signed [DW-1:0] a_dx1, a_dy1, a_dx2, a_dy2;
    logic signed [EW-1:0] area2;

    logic pos, neg, gt, lt, zero;
    logic inside_d, edge_d;

    assign p_ready = (state_q == RUN);

    // Twice the signed area using the two stored vertices and the incoming one.
    assign a_dx1 = $signed({1'b0, vx_q[1]}) - $signed({1'b0, vx_q[0]});
    assign a_dy1 = $signed({1'b0, vy_q[1]}) - $signed({1'b0, vy_q[0]});
    assign a_dx2 = $signed({1'b0, v_x}) - $signed({1'b0, vx_q[0]});
    assign a_dy2 = $signed({1'b0, v_y}) - $signed({1'b0, vy_q[0]});
    assign area2 = EW'(PW'(a_dx1) * PW'(a_dy2)) - EW'(PW'(a_dy1) * PW'(a_dx2));

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q   <= LOAD0;
            vx_q      <= '{default: '0};
            vy_q      <= '{default: '0};
            tri_degen <= 1'b0;
        end else if (v_valid) begin
            unique case (state_q)
                LOAD0: begin
                    vx_q[0] <= v_x;
                    vy_q[0] <= v_y;
                    state_q <= LOAD1;
                end
                LOAD1: begin
                    vx_q[1] <= v_x;
                    vy_q[1] <= v_y;
                    state_q <= LOAD2;
                end
                LOAD2: begin
                    vx_q[2]   <= v_x;
                    vy_q[2]   <= v_y;
                    tri_degen <= (area2 == '0);
                    state_q   <= RUN;
                end
                RUN: begin
                    vx_q[0] <= v_x;
                    vy_q[0] <= v_y;
                    state_q <= LOAD1;
                end
            endcase
        end
    end

    // Edge k runs from vertex k to vertex (k+1)%3.
    for (genvar k = 0; k < 3; k++) begin : g_edge
        tri_edge_fn #(.W(W)) u_edge (
            .clk  (clk),
            .rst  (r),
            .ax_i (vx_q[k]),
            .ay_i (vy_q[k]),
            .bx_i (vx_q[(k + 1) % 3]),
            .by_i (vy_q[(k + 1) % 3]),
            .px_i (p_x),
            .py_i (p_y),
            .e_o  (e[k])
        );
    end

    always_comb begin
        pos  = 1'b1;
        neg  = 1'b1;
        gt   = 1'b1;
        lt   = 1'b1;
        zero = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (e[k][EW-1]) begin
                pos = 1'b0;
                gt  = 1'b0;
            end else if (|e[k]) begin
                neg = 1'b0;
                lt  = 1'b0;
            end else begin
                gt   = 1'b0;
                lt   = 1'b0;
                zero = 1'b1;
            end
        end
        inside_d = ~deg2_q & ((INCLUSIVE != 0) ? (pos | neg) : (gt | lt));
        edge_d   = ~deg2_q & zero & (pos | neg);
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            tag1_q     <= '0;
            tag2_q     <= '0;
            deg1_q     <= 1'b0;
            deg2_q     <= 1'b0;
            out_valid  <= 1'b0;
            out_inside <= 1'b0;
            out_edge   <= 1'b0;
            out_tag    <= '0;
        end else begin
            v1_q      <= p_valid & p_ready;
            tag1_q    <= p_tag;
            deg1_q    <= tri_degen;
            v2_q      <= v1_q;
            tag2_q    <= tag1_q;
            deg2_q    <= deg1_q;
            out_valid <= v2_q;
            if (v2_q) begin
                out_inside <= inside_d;
                out_edge   <= edge_d;
                out_tag    <= tag2_q;
            end
        end
    end

endmodule

// File: tb/tb_tri_stream_test.sv
// Bench for tri_stream_test: reference model pushes expected verdicts on
// acceptance, a negedge monitor pops and compares; tasks cover each scenario.
module tb_tri_stream_test;

    localparam int W     = 11;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             r = 1'b1;
    logic             v_valid = 1'b0;
    logic [W-1:0]     v_x = '0, v_y = '0;
    logic             p_valid = 1'b0;
    logic [W-1:0]     p_x = '0, p_y = '0;
    logic [TAG_W-1:0] p_tag = '0;

    logic             p_ready, out_valid, out_inside, out_edge, tri_degen;
    logic [TAG_W-1:0] out_tag;
    logic             p_ready0, out_valid0, out_inside0, out_edge0, tri_degen0;
    logic [TAG_W-1:0] out_tag0;

    tri_stream_test #(.W(W), .TAG_W(TAG_W), .INCLUSIVE(1)) dut (
        .clk(clk), .r(r), .v_valid(v_valid), .v_x(v_x), .v_y(v_y),
        .p_valid(p_valid), .p_ready(p_ready), .p_x(p_x), .p_y(p_y),
        .p_tag(p_tag), .out_valid(out_valid), .out_inside(out_inside),
        .out_edge(out_edge), .out_tag(out_tag), .tri_degen(tri_degen)
    );

    tri_stream_test #(.W(W), .TAG_W(TAG_W), .INCLUSIVE(0)) dut_strict (
        .clk(clk), .r(r), .v_valid(v_valid), .v_x(v_x), .v_y(v_y),
        .p_valid(p_valid), .p_ready(p_ready0), .p_x(p_x), .p_y(p_y),
        .p_tag(p_tag), .out_valid(out_valid0), .out_inside(out_inside0),
        .out_edge(out_edge0), .out_tag(out_tag0), .tri_degen(tri_degen0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        bit         ins1;
        bit         ins0;
        bit         edg;
        logic [3:0] tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   ms = 0;
    bit   mdeg = 0;
    longint mx [3];
    longint my [3];

    function automatic longint efn(longint ax, longint ay, longint bx,
                                   longint by, longint px, longint py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    // Reference model, sampled on the same edges as the DUT.
    always @(posedge clk or posedge r) begin
        if (r) begin
            ms = 0;
            mdeg = 0;
            for (int k = 0; k < 3; k++) begin
                mx[k] = 0;
                my[k] = 0;
            end
            q.delete();
        end else begin
            cyc++;
            if (p_valid && ms == 3) begin
                exp_t x;
                longint ev [3];
                int np, nn, nz;
                np = 0; nn = 0; nz = 0;
                for (int k = 0; k < 3; k++) begin
                    ev[k] = efn(mx[k], my[k], mx[(k+1)%3], my[(k+1)%3],
                                longint'(p_x), longint'(p_y));
                    if (ev[k] > 0) np++;
                    else if (ev[k] < 0) nn++;
                    else nz++;
                end
                x.c    = cyc + 2;
                x.ins1 = !mdeg && (np == 0 || nn == 0);
                x.ins0 = !mdeg && nz == 0 && (np == 3 || nn == 3);
                x.edg  = !mdeg && nz > 0 && (np == 0 || nn == 0);
                x.tag  = p_tag;
                q.push_back(x);
            end
            if (v_valid) begin
                case (ms)
                    0: begin mx[0] = v_x; my[0] = v_y; ms = 1; end
                    1: begin mx[1] = v_x; my[1] = v_y; ms = 2; end
                    2: begin
                        mx[2] = v_x; my[2] = v_y; ms = 3;
                        mdeg = (efn(mx[0], my[0], mx[1], my[1], mx[2], my[2]) == 0);
                    end
                    default: begin mx[0] = v_x; my[0] = v_y; ms = 1; end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!r) begin
            if (out_valid0 !== out_valid) begin
                total++; bad++;
                $display("FAIL strict_valid got=%b want=%b", out_valid0, out_valid);
            end
            if (out_valid) begin
                n_out++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out cyc=%0d tag=%0d", cyc, out_tag);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    if (cyc !== x.c || out_inside !== x.ins1 || out_edge !== x.edg ||
                        out_tag !== x.tag || out_inside0 !== x.ins0 ||
                        out_edge0 !== x.edg) begin
                        bad++;
                        $display("FAIL result cyc=%0d/%0d ins=%b/%b edge=%b/%b tag=%0d/%0d strict_ins=%b/%b strict_edge=%b/%b",
                                 cyc, x.c, out_inside, x.ins1, out_edge, x.edg,
                                 out_tag, x.tag, out_inside0, x.ins0, out_edge0, x.edg);
                    end
                end
            end
        end
    end

    task automatic load(input int x0, y0, x1, y1, x2, y2);
        v_valid = 1'b1;
        v_x = W'(x0); v_y = W'(y0);
        @(negedge clk);
        v_x = W'(x1); v_y = W'(y1);
        @(negedge clk);
        v_x = W'(x2); v_y = W'(y2);
        @(negedge clk);
        v_valid = 1'b0;
    endtask

    task automatic query(input int x, y, t);
        p_valid = 1'b1;
        p_x = W'(x); p_y = W'(y); p_tag = TAG_W'(t);
        @(negedge clk);
        p_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int i = 0;
        while (q.size() != 0 && i < 30) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain pending=%0d want=0", nm, q.size());
        end
    endtask

    task automatic test_reset();
        r = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({p_ready, out_valid, out_inside, out_edge, out_tag, tri_degen} !== '0) begin
            bad++;
            $display("FAIL reset_state rdy=%b v=%b in=%b e=%b tag=%0d deg=%b want=0",
                     p_ready, out_valid, out_inside, out_edge, out_tag, tri_degen);
        end
        r = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        query(3, 3, 9);
        total++;
        if (p_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_ready got=%b want=0", p_ready);
        end
        load(0, 0, 10, 0, 0, 10);
        total++;
        if (p_ready !== 1'b1 || tri_degen !== 1'b0) begin
            bad++;
            $display("FAIL basic_loaded rdy=%b deg=%b want=1,0", p_ready, tri_degen);
        end
        query(2, 2, 1);
        query(5, 5, 2);
        query(11, 0, 3);
        query(0, 0, 4);
        drain("basic");
    endtask

    task automatic test_reverse();
        load(0, 0, 0, 10, 10, 0);
        query(2, 2, 5);
        query(2047, 2047, 6);
        query(10, 0, 7);
        load(2047, 0, 0, 2047, 2047, 2047);
        query(2047, 2047, 8);
        query(0, 0, 9);
        query(1500, 1500, 10);
        query(1024, 1023, 11);
        drain("reverse");
    endtask

    task automatic test_degen();
        load(0, 0, 5, 5, 10, 10);
        total++;
        if (tri_degen !== 1'b1) begin
            bad++;
            $display("FAIL degen_flag got=%b want=1", tri_degen);
        end
        query(3, 3, 12);
        query(1, 0, 13);
        drain("degen");
        load(0, 0, 10, 0, 0, 10);
        total++;
        if (tri_degen !== 1'b0) begin
            bad++;
            $display("FAIL degen_clear got=%b want=0", tri_degen);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        int nv [3][2];
        nv = '{'{2, 2}, '{14, 3}, '{4, 14}};
        load(0, 0, 12, 0, 0, 12);
        n0 = n_out;
        for (int i = 0; i < 20; i++) begin
            p_valid = 1'b1;
            p_x = W'($urandom_range(0, 15));
            p_y = W'($urandom_range(0, 15));
            p_tag = TAG_W'(i);
            v_valid = (i >= 10 && i <= 12);
            if (v_valid) begin
                v_x = W'(nv[i-10][0]);
                v_y = W'(nv[i-10][1]);
            end
            total++;
            if (p_ready !== !(i == 11 || i == 12)) begin
                bad++;
                $display("FAIL b2b_ready i=%0d got=%b want=%b", i, p_ready,
                         !(i == 11 || i == 12));
            end
            @(negedge clk);
        end
        p_valid = 1'b0;
        v_valid = 1'b0;
        drain("b2b");
        total++;
        if (n_out - n0 !== 18) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=18", n_out - n0);
        end
    endtask

    task automatic test_async_reset();
        load(0, 0, 10, 0, 0, 10);
        for (int i = 0; i < 6; i++) query(i, i, i);
        @(posedge clk);
        #2 r = 1'b1;
        #1;
        total++;
        if ({p_ready, out_valid, out_inside, out_edge, out_tag, tri_degen} !== '0) begin
            bad++;
            $display("FAIL async_clear rdy=%b v=%b in=%b e=%b tag=%0d deg=%b want=0",
                     p_ready, out_valid, out_inside, out_edge, out_tag, tri_degen);
        end
        @(negedge clk);
        r = 1'b0;
        p_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL async_quiet i=%0d got=%b want=0", i, out_valid);
            end
        end
        p_valid = 1'b0;
        load(1, 1, 20, 2, 3, 25);
        query(5, 5, 14);
        query(30, 30, 15);
        drain("async");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reverse();
        test_degen();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
